bird_motion_ctrl: RTL and testbench

Parametrised bird controller for the flappy-bird game: it owns the bird FSM, the bird's vertical position, the flap/rise timing and the handshake to the VGA renderer. It is a frame-paced successor of the existing bird control FSM, with configurable playfield height, rise/fall step sizes and rise duration. Ceiling and floor detection are internal, and a post-crash hold period is included. It sits between the keyboard/key debouncer, the pipe-collision checker (`touched`) and the drawing datapath.

---
 rtl/bird_motion_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_bird_motion_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bird_motion_ctrl.sv
// Frame-paced bird controller: owns the bird FSM, vertical position, rise timing,
// post-crash hold and the DRAW handshake with the renderer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// START   | idle at Y_START, waits for a latched flap
// RAISING | moving up RISE_STEP rows per frame for RISE_FRAMES frames
// FALLING | moving down FALL_STEP rows per frame until flap or crash
// STOP    | crashed, holds for STOP_FRAMES frames then returns to START
// DRAW    | renderer busy; leaves to after_draw on draw_done
module bird_motion_ctrl #(
    parameter int Y_W         = 7,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 119,
    parameter int Y_START     = 60,
    parameter int RISE_STEP   = 2,
    parameter int FALL_STEP   = 1,
    parameter int RISE_FRAMES = 4,
    parameter int STOP_FRAMES = 30
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           frame_tick,
    input  logic           press_key,
    input  logic           touched,
    input  logic           draw_done,
    output logic [2:0]     current,
    output logic           draw_req,
    output logic [Y_W-1:0] bird_y,
    output logic           game_over,
    output logic           frame_overrun
);

    typedef enum logic [2:0] {
        S_START   = 3'b001,
        S_RAISING = 3'b010,
        S_FALLING = 3'b011,
        S_STOP    = 3'b100,
        S_DRAW    = 3'b111
    } state_t;

    localparam int YW1  = Y_W + 1;
    localparam int RC_W = (RISE_FRAMES < 1) ? 1 : $clog2(RISE_FRAMES + 1);
    localparam int SC_W = (STOP_FRAMES < 1) ? 1 : $clog2(STOP_FRAMES + 1);

    localparam logic [Y_W:0]    YMIN_W    = YW1'(Y_MIN);
    localparam logic [Y_W:0]    YMAX_W    = YW1'(Y_MAX);
    localparam logic [Y_W:0]    RISE_W    = YW1'(RISE_STEP);
    localparam logic [Y_W:0]    FALL_W    = YW1'(FALL_STEP);
    localparam logic [Y_W-1:0]  YSTART_V  = Y_W'(Y_START);
    localparam logic [RC_W-1:0] RISE_LOAD = RC_W'(RISE_FRAMES);
    localparam logic [SC_W-1:0] STOP_LOAD = SC_W'(STOP_FRAMES);

    state_t          state_q;
    state_t          after_draw;
    logic [Y_W-1:0]  y_q;
    logic [RC_W-1:0] rise_cnt;
    logic [SC_W-1:0] stop_cnt;
    logic            press_prev;
    logic            press_lat;
    logic            press_now;

    state_t          nxt_after;
    logic [Y_W-1:0]  nxt_y;
    logic [RC_W-1:0] nxt_rise;
    logic [SC_W-1:0] nxt_stop;
    logic [RC_W-1:0] rise_dec;
    logic [SC_W-1:0] stop_dec;
    logic [Y_W:0]    y_wide;
    logic [Y_W:0]    up_wide;
    logic [Y_W:0]    dn_wide;
    logic            enter_stop;

    // An edge arriving on the same clock as frame_tick still counts for that tick.
    assign press_now = press_lat | (press_key & ~press_prev);

    assign current = state_q;
    assign bird_y  = y_q;

    always_comb begin
        y_wide     = {1'b0, y_q};
        up_wide    = (y_wide >= YMIN_W + RISE_W) ? (y_wide - RISE_W) : YMIN_W;
        dn_wide    = y_wide + FALL_W;
        if (dn_wide > YMAX_W) begin
            dn_wide = YMAX_W;
        end
        rise_dec   = (rise_cnt == '0) ? '0 : rise_cnt - 1'b1;
        stop_dec   = (stop_cnt == '0) ? '0 : stop_cnt - 1'b1;

        nxt_after  = state_q;
        nxt_y      = y_q;
        nxt_rise   = rise_cnt;
        nxt_stop   = stop_cnt;
        enter_stop = 1'b0;

        case (state_q)
            S_START: begin
                if (press_now) begin
                    nxt_after = S_RAISING;
                    nxt_rise  = RISE_LOAD;
                end
            end
            S_RAISING: begin
                nxt_y    = up_wide[Y_W-1:0];
                nxt_rise = rise_dec;
                if (touched) begin
                    enter_stop = 1'b1;
                end else if (press_now) begin
                    nxt_rise = RISE_LOAD;
                end else if (rise_dec == '0 || up_wide == YMIN_W) begin
                    nxt_after = S_FALLING;
                end
            end
            S_FALLING: begin
                nxt_y = dn_wide[Y_W-1:0];
                if (touched || dn_wide == YMAX_W) begin
                    enter_stop = 1'b1;
                end else if (press_now) begin
                    nxt_after = S_RAISING;
                    nxt_rise  = RISE_LOAD;
                end
            end
            S_STOP: begin
                nxt_stop = stop_dec;
                if (stop_dec == '0) begin
                    nxt_after = S_START;
                    nxt_y     = YSTART_V;
                end
            end
            default: begin
            end
        endcase

        if (enter_stop) begin
            nxt_after = S_STOP;
            nxt_stop  = STOP_LOAD;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_START;
            after_draw    <= S_START;
            y_q           <= YSTART_V;
            rise_cnt      <= '0;
            stop_cnt      <= '0;
            press_prev    <= 1'b0;
            press_lat     <= 1'b0;
            draw_req      <= 1'b0;
            game_over     <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            press_prev <= press_key;
            game_over  <= 1'b0;
            case (state_q)
                S_START, S_RAISING, S_FALLING, S_STOP: begin
                    if (frame_tick) begin
                        state_q    <= S_DRAW;
                        draw_req   <= 1'b1;
                        after_draw <= nxt_after;
                        y_q        <= nxt_y;
                        rise_cnt   <= nxt_rise;
                        stop_cnt   <= nxt_stop;
                        press_lat  <= 1'b0;
                        game_over  <= enter_stop;
                    end else begin
                        press_lat <= press_now;
                    end
                end
                S_DRAW: begin
                    press_lat <= press_now;
                    // Ticks are not queued while the renderer is busy.
                    if (frame_tick) begin
                        frame_overrun <= 1'b1;
                    end
                    if (draw_done) begin
                        state_q  <= after_draw;
                        draw_req <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_START;
                    draw_req  <= 1'b0;
                    press_lat <= press_now;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl: a frame-level behavioural model checked
// every cycle, plus hand-computed position/state expectations.
module tb_bird_motion_ctrl;

    localparam int ST_START = 1;
    localparam int ST_RISE  = 2;
    localparam int ST_FALL  = 3;
    localparam int ST_STOP  = 4;
    localparam int ST_DRAW  = 7;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       press_key = 1'b0;
    logic       touched = 1'b0;
    logic       draw_done = 1'b0;
    logic [2:0] current;
    logic       draw_req;
    logic [6:0] bird_y;
    logic       game_over;
    logic       frame_overrun;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    // model of the bird, in frame-level terms
    int m_cur   = ST_START;
    int m_after = ST_START;
    int m_y     = 60;
    int m_rise  = 0;
    int m_stop  = 0;
    bit m_latch = 0;
    bit m_prev  = 0;
    bit m_go    = 0;
    bit m_ovr   = 0;

    bird_motion_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .frame_tick    (frame_tick),
        .press_key     (press_key),
        .touched       (touched),
        .draw_done     (draw_done),
        .current       (current),
        .draw_req      (draw_req),
        .bird_y        (bird_y),
        .game_over     (game_over),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_cur = ST_START; m_after = ST_START; m_y = 60; m_rise = 0; m_stop = 0;
            m_latch = 0; m_prev = 0; m_go = 0; m_ovr = 0;
        end else begin
            bit flap;
            flap   = m_latch || (press_key && !m_prev);
            m_prev = press_key;
            m_go   = 0;
            if (m_cur == ST_DRAW) begin
                if (frame_tick) m_ovr = 1;
                m_latch = flap;
                if (draw_done) m_cur = m_after;
            end else if (frame_tick) begin
                m_latch = 0;
                m_after = m_cur;
                if (m_cur == ST_START) begin
                    if (flap) begin m_after = ST_RISE; m_rise = 4; end
                end else if (m_cur == ST_RISE) begin
                    m_y    = (m_y - 2 < 0) ? 0 : m_y - 2;
                    m_rise = m_rise - 1;
                    if (touched) begin m_after = ST_STOP; m_stop = 30; m_go = 1; end
                    else if (flap) m_rise = 4;
                    else if (m_rise == 0 || m_y == 0) m_after = ST_FALL;
                end else if (m_cur == ST_FALL) begin
                    m_y = (m_y + 1 > 119) ? 119 : m_y + 1;
                    if (touched || m_y == 119) begin m_after = ST_STOP; m_stop = 30; m_go = 1; end
                    else if (flap) begin m_after = ST_RISE; m_rise = 4; end
                end else begin
                    m_stop = m_stop - 1;
                    if (m_stop == 0) begin m_after = ST_START; m_y = 60; end
                end
                m_cur = ST_DRAW;
            end else begin
                m_latch = flap;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_cmp++;
            if (current !== 3'(m_cur) || draw_req !== (m_cur == ST_DRAW) || bird_y !== 7'(m_y)
                || game_over !== m_go || frame_overrun !== m_ovr) begin
                n_bad++;
                $display("FAIL model t=%0t: cur/req/y/go/ovr got %0d/%0b/%0d/%0b/%0b expected %0d/%0b/%0d/%0b/%0b",
                         $time, current, draw_req, bird_y, game_over, frame_overrun,
                         m_cur, (m_cur == ST_DRAW), m_y, m_go, m_ovr);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_frame(input bit tch, input bit prs);
        touched = tch; press_key = prs; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; touched = 1'b0; press_key = 1'b0; draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
    endtask

    task automatic press();
        press_key = 1'b1;
        @(negedge clk);
        press_key = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        chk_on = 1;
        chk("reset_state", int'(current), ST_START);
        chk("reset_y", int'(bird_y), 60);
        chk("reset_req", int'(draw_req), 0);

        repeat (3) do_frame(0, 0);
        chk("idle_state", int'(current), ST_START);
        chk("idle_y", int'(bird_y), 60);

        press();
        do_frame(0, 0);
        chk("flap_state", int'(current), ST_RISE);
        chk("flap_y", int'(bird_y), 60);
        do_frame(0, 0); chk("rise1_y", int'(bird_y), 58);
        do_frame(0, 0); chk("rise2_y", int'(bird_y), 56);
        do_frame(0, 0); chk("rise3_y", int'(bird_y), 54);
        do_frame(0, 0); chk("rise4_y", int'(bird_y), 52);
        chk("rise_end_state", int'(current), ST_FALL);
        do_frame(0, 0);
        chk("fall1_y", int'(bird_y), 53);

        press();
        do_frame(0, 0);
        chk("reflap_state", int'(current), ST_RISE);
        chk("reflap_y", int'(bird_y), 54);
        for (int k = 0; k < 26; k++) begin
            press();
            do_frame(0, 0);
        end
        chk("near_ceil_y", int'(bird_y), 2);
        chk("near_ceil_state", int'(current), ST_RISE);
        do_frame(0, 0);
        chk("ceil_y", int'(bird_y), 0);
        chk("ceil_state", int'(current), ST_FALL);

        for (int k = 0; k < 118; k++) do_frame(0, 0);
        chk("near_floor_y", int'(bird_y), 118);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("floor_go_pulse", int'(game_over), 1);
        chk("floor_y", int'(bird_y), 119);
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        chk("floor_go_clear", int'(game_over), 0);
        chk("floor_state", int'(current), ST_STOP);

        repeat (29) do_frame(0, 0);
        chk("stop_hold_state", int'(current), ST_STOP);
        chk("stop_hold_y", int'(bird_y), 119);
        do_frame(0, 0);
        chk("stop_done_state", int'(current), ST_START);
        chk("stop_done_y", int'(bird_y), 60);

        press();
        do_frame(0, 0);
        do_frame(1, 1);
        chk("touch_press_state", int'(current), ST_STOP);
        chk("touch_press_y", int'(bird_y), 58);
        repeat (30) do_frame(0, 0);
        chk("recover_state", int'(current), ST_START);
        chk("recover_y", int'(bird_y), 60);

        press();
        do_frame(0, 0);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("draw_y", int'(bird_y), 58);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("overrun_flag", int'(frame_overrun), 1);
        chk("overrun_y", int'(bird_y), 58);
        chk("overrun_state", int'(current), ST_DRAW);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_state", int'(current), ST_START);
        chk("async_rst_y", int'(bird_y), 60);
        chk("async_rst_ovr", int'(frame_overrun), 0);
        chk("async_rst_req", int'(draw_req), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk_on = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
